mem_stage_wb_master: RTL

//  Parametrised memory-stage peripheral bus master, generalising the single-UART MEM-stage access.

---
 rtl/mem_stage_wb_master_if.sv | 26 ++
 rtl/mem_stage_wb_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wb_master_if.sv
// Pipelined Wishbone B4 bus bundle between the MEM-stage master and N_SLAVES slave windows.
// cyc/stall/ack/err are one bit per slave; read data is packed with slave k at [32k+31:32k].
interface mem_stage_wb_master_if #(
  parameter int N_SLAVES = 2
) ();
  logic [N_SLAVES-1:0]    wbm_cyc_o;
  logic                   wbm_stb_o;
  logic                   wbm_we_o;
  logic [31:0]            wbm_addr_o;
  logic [31:0]            wbm_data_o;
  logic [3:0]             wbm_sel_o;
  logic [N_SLAVES-1:0]    wbm_stall_i;
  logic [N_SLAVES-1:0]    wbm_ack_i;
  logic [N_SLAVES-1:0]    wbm_err_i;
  logic [32*N_SLAVES-1:0] wbm_data_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o,
    input  wbm_stall_i, wbm_ack_i, wbm_err_i, wbm_data_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o,
    output wbm_stall_i, wbm_ack_i, wbm_err_i, wbm_data_i
  );
endinterface

// File: rtl/mem_stage_wb_master.sv
// MEM-stage load/store master onto N_SLAVES pipelined Wishbone windows, stalling the pipeline until done.
// Define WB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles with a bus error.
module mem_stage_wb_master #(
  parameter int         N_SLAVES    = 2,
  parameter logic [3:0] PERIPH_BASE = 4'h2
`ifdef WB_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        hit_o,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        bus_err_o,
  mem_stage_wb_master_if.master wb
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [4:0] NUM_SLV = 5'(N_SLAVES);

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_sel, r_idx;
  logic [2:0]  r_funct3;
  logic        r_we, r_err;

  logic [3:0]  w_idx, w_sel;
  logic [31:0] w_wdata, w_slvData, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_inPage, w_mapped, w_misal, w_hit, w_accErr, w_accept;
  logic        w_slvStall, w_slvAck, w_slvErr, w_active, w_timeout;

  // The peripheral page spans eight windows above PERIPH_BASE; only the first N_SLAVES exist.
  assign w_idx    = req_addr_i[31:28] - PERIPH_BASE;
  assign w_inPage = ~w_idx[3];
  assign w_mapped = w_inPage & ({1'b0, w_idx} < NUM_SLV);
  assign w_hit    = req_valid_i & w_mapped;
  assign w_accErr = req_valid_i & w_inPage & (~w_mapped | w_misal);
  assign w_accept = (r_state == IDLE) & w_hit & ~w_accErr;
  assign hit_o    = w_hit;

  always_comb begin
    w_misal = 1'b0;
    w_sel   = 4'hF;
    w_wdata = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        w_sel   = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_misal = req_addr_i[0];
        w_sel   = 4'b0011 << {req_addr_i[1], 1'b0};
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      2'b10:   w_misal = |req_addr_i[1:0];
      default: w_misal = 1'b1;
    endcase
  end

  always_comb begin
    w_slvStall = 1'b0;
    w_slvAck   = 1'b0;
    w_slvErr   = 1'b0;
    w_slvData  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_idx == 4'(k)) begin
        w_slvStall = wb.wbm_stall_i[k];
        w_slvAck   = wb.wbm_ack_i[k];
        w_slvErr   = wb.wbm_err_i[k];
        w_slvData  = wb.wbm_data_i[32*k +: 32];
      end
    end
  end

  assign w_byte = w_slvData[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = w_slvData[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = w_slvData;
    case (r_funct3[1:0])
      2'b00:   w_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default: w_ext = w_slvData;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  logic [31:0] r_timer;

  // Timer is held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               r_timer <= '0;
    else if (r_state != WAIT)  r_timer <= '0;
    else                       r_timer <= r_timer + 32'd1;
  end

  assign w_timeout = (r_timer == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Access errors answer in IDLE without a bus cycle; DONE releases the stall and ignores the held request.
  always_comb begin
    w_next       = r_state;
    w_active     = 1'b0;
    wb.wbm_stb_o = 1'b0;
    stall_o      = 1'b0;
    rsp_valid_o  = 1'b0;
    bus_err_o    = 1'b0;
    case (r_state)
      IDLE: begin
        stall_o     = w_accept;
        rsp_valid_o = w_accErr;
        bus_err_o   = w_accErr;
        if (w_accept) w_next = REQ;
      end
      REQ: begin
        w_active     = 1'b1;
        wb.wbm_stb_o = 1'b1;
        stall_o      = 1'b1;
        if (!w_slvStall) w_next = WAIT;
      end
      WAIT: begin
        w_active = 1'b1;
        stall_o  = 1'b1;
        if (w_slvAck | w_slvErr | w_timeout) w_next = DONE;
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        bus_err_o   = r_err;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    wb.wbm_cyc_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      wb.wbm_cyc_o[k] = w_active & (r_idx == 4'(k));
    end
  end

  // Request fields are captured once at acceptance; error wins over a simultaneous ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_funct3 <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_addr_i;
        r_wdata  <= w_wdata;
        r_sel    <= w_sel;
        r_we     <= req_we_i;
        r_idx    <= w_idx;
        r_funct3 <= req_funct3_i;
        r_err    <= 1'b0;
      end
      if (r_state == WAIT) begin
        if (w_slvErr || (!w_slvAck && w_timeout)) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else if (w_slvAck) begin
          r_err   <= 1'b0;
          r_rdata <= r_we ? 32'd0 : w_ext;
        end
      end
    end
  end

  assign wb.wbm_we_o   = r_we;
  assign wb.wbm_addr_o = r_addr;
  assign wb.wbm_data_o = r_wdata;
  assign wb.wbm_sel_o  = r_sel;
  assign rsp_rdata_o   = (r_state == DONE) ? r_rdata : 32'd0;

endmodule
